// File: rtl/i2c_pkg.sv
// ============================================================================
// Package : i2c_pkg
// Shared FSM state encoding and byte constant for the I2C register target.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

   localparam int I2C_BYTE_BITS = 8;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK
   } i2c_state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_line_filter.sv
// ============================================================================
// Module : i2c_line_filter
// Two-flop synchroniser plus FILT_LEN-sample stability filter with edge pulses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_line_filter
   import i2c_pkg::*;
#(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [1:0]          sync_q;
   logic [FILT_LEN-1:0] hist_q;
   logic                level_q;

   // Idle bus level is high, so everything resets to 1 to avoid a false edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b11;
         hist_q  <= '1;
         level_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[0], line_i};
         hist_q <= {hist_q[FILT_LEN-2:0], sync_q[1]};
         if (rise_o) begin
            level_q <= 1'b1;
         end else if (fall_o) begin
            level_q <= 1'b0;
         end
      end
   end

   assign rise_o  = (&hist_q) & ~level_q;
   assign fall_o  = ~(|hist_q) & level_q;
   assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_regs.sv
// ============================================================================
// Module : i2c_slave_regs
// I2C target with address match, register pointer and auto-incrementing port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_slave_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         AW       = 5,
   parameter int         FILT_LEN = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   output logic [AW-1:0] reg_addr,
   output logic [7:0]    wr_data,
   output logic          wr_en,
   output logic          rd_en,
   input  logic [7:0]    rd_data,
   output logic          busy
);

   localparam logic [3:0] C_BITS = 4'(I2C_BYTE_BITS);

   logic w_scl_lvl, w_scl_rise, w_scl_fall;
   logic w_sda_lvl, w_sda_rise, w_sda_fall;
   logic w_start, w_stop, w_last_bit;
   logic [7:0] w_rx_next;

   i2c_state_e    state_q, state_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic [6:0]    rx_q, rx_d;
   logic [7:0]    tx_q, tx_d;
   logic [7:0]    wdat_q, wdat_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic          rw_q, rw_d;
   logic          oe_q, oe_d;
   logic          busy_q, busy_d;
   logic          wr_en_q, wr_en_d;
   logic          rd_en_q, rd_en_d;
   logic          ld_q;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk    (clk),
      .reset  (reset),
      .line_i (scl_i),
      .level_o(w_scl_lvl),
      .rise_o (w_scl_rise),
      .fall_o (w_scl_fall)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk    (clk),
      .reset  (reset),
      .line_i (sda_i),
      .level_o(w_sda_lvl),
      .rise_o (w_sda_rise),
      .fall_o (w_sda_fall)
   );

   assign w_start    = w_sda_fall & w_scl_lvl;
   assign w_stop     = w_sda_rise & w_scl_lvl;
   assign w_rx_next  = {rx_q, w_sda_lvl};
   assign w_last_bit = (bitcnt_q == 4'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         bitcnt_q <= '0;
         rx_q     <= '0;
         tx_q     <= '0;
         wdat_q   <= '0;
         ptr_q    <= '0;
         rw_q     <= 1'b0;
         oe_q     <= 1'b0;
         busy_q   <= 1'b0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         ld_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         rx_q     <= rx_d;
         tx_q     <= tx_d;
         wdat_q   <= wdat_d;
         ptr_q    <= ptr_d;
         rw_q     <= rw_d;
         oe_q     <= oe_d;
         busy_q   <= busy_d;
         wr_en_q  <= wr_en_d;
         rd_en_q  <= rd_en_d;
         ld_q     <= rd_en_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      rx_d     = rx_q;
      tx_d     = tx_q;
      wdat_d   = wdat_q;
      ptr_d    = ptr_q;
      rw_d     = rw_q;
      oe_d     = oe_q;
      busy_d   = busy_q;
      wr_en_d  = 1'b0;
      rd_en_d  = 1'b0;

      // rd_data is valid the cycle after the rd_en strobe
      if (ld_q) begin
         tx_d = rd_data;
      end

      if (w_stop) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (w_start) begin
         state_d  = ADDR;
         bitcnt_d = C_BITS;
         oe_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR, PTR, WDATA: begin
               if (w_scl_rise) begin
                  rx_d     = w_rx_next[6:0];
                  bitcnt_d = bitcnt_q - 4'd1;
                  if (w_last_bit) begin
                     if (state_q == PTR) begin
                        ptr_d   = w_rx_next[AW-1:0];
                        state_d = PTR_ACK;
                     end else if (state_q == WDATA) begin
                        wr_en_d = 1'b1;
                        wdat_d  = w_rx_next;
                        state_d = WDATA_ACK;
                     end else if (w_rx_next[7:1] == DEV_ADDR) begin
                        rw_d    = w_rx_next[0];
                        busy_d  = 1'b1;
                        state_d = ADDR_ACK;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
            end
            // oe_q doubles as the phase flag: low = ACK not yet driven
            ADDR_ACK, PTR_ACK, WDATA_ACK: begin
               if (w_scl_fall && !oe_q) begin
                  oe_d = 1'b1;
               end else if (w_scl_fall) begin
                  oe_d     = 1'b0;
                  bitcnt_d = C_BITS;
                  if (state_q == WDATA_ACK) begin
                     ptr_d   = ptr_q + 1'b1;
                     state_d = WDATA;
                  end else if (state_q == PTR_ACK) begin
                     state_d = WDATA;
                  end else if (!rw_q) begin
                     state_d = PTR;
                  end else begin
                     oe_d     = ~tx_q[7];
                     tx_d     = {tx_q[6:0], 1'b0};
                     bitcnt_d = C_BITS - 4'd1;
                     state_d  = RDATA;
                  end
               end else if (w_scl_rise && oe_q && rw_q && state_q == ADDR_ACK) begin
                  rd_en_d = 1'b1;
               end
            end
            RDATA: begin
               if (w_scl_fall) begin
                  if (bitcnt_q == 4'd0) begin
                     oe_d    = 1'b0;
                     state_d = RDATA_ACK;
                  end else begin
                     oe_d     = ~tx_q[7];
                     tx_d     = {tx_q[6:0], 1'b0};
                     bitcnt_d = bitcnt_q - 4'd1;
                  end
               end
            end
            RDATA_ACK: begin
               if (w_scl_rise) begin
                  if (!w_sda_lvl) begin
                     ptr_d    = ptr_q + 1'b1;
                     rd_en_d  = 1'b1;
                     bitcnt_d = C_BITS;
                     state_d  = RDATA;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign sda_oe   = oe_q;
   assign reg_addr = ptr_q;
   assign wr_data  = wdat_q;
   assign wr_en    = wr_en_q;
   assign rd_en    = rd_en_q;
   assign busy     = busy_q;

endmodule

`default_nettype wire
